// File: rtl/div_unit_if.sv
// Pipeline <-> divider handshake: EX-stage request, flush abort, result and stall.
interface div_unit_if;
  logic        start_i;
  logic        signed_div_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  modport master (
    output start_i, signed_div_i, annul_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, signed_div_i, annul_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stall_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Result layout is {remainder (HI), quotient (LO)}.
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  div_bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] divisor_q, divisor_d;
  logic        signed_q, signed_d;
  logic        sign1_q, sign1_d;
  logic        sign2_q, sign2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic        stall_s;
  logic        accept_s;
  logic        last_step_s;
  logic [64:0] shifted_s;
  logic [32:0] trial_s;
  logic [64:0] step_s;

  function automatic logic [31:0] cond_neg(input logic [31:0] value, input logic neg);
    if (neg) begin
      cond_neg = (~value) + 32'd1;
    end else begin
      cond_neg = value;
    end
  endfunction

  assign accept_s    = div_bus.start_i & ~div_bus.annul_i;
  assign last_step_s = ((cnt_q + 6'd1) == 6'd32);

  // One restoring step: shift left, subtract the divisor if it fits, shift in the quotient bit.
  always_comb begin
    shifted_s = acc_q << 6'd1;
    trial_s   = shifted_s[64:32] - {1'b0, divisor_q};
    if (shifted_s[64:32] >= {1'b0, divisor_q}) begin
      step_s = {trial_s, shifted_s[31:1], 1'b1};
    end else begin
      step_s = shifted_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an annul in BYZERO/ON drops the operation without a ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (div_bus.opdata2_i == 32'd0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d = ST_ON;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BYZERO: begin
        if (div_bus.annul_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_END;
        end
      end
      ST_ON: begin
        if (div_bus.annul_i) begin
          state_d = ST_IDLE;
        end else if (last_step_s) begin
          state_d = ST_END;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall output: the request cycle itself stalls, END releases the pipeline.
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      ST_IDLE:   stall_s = accept_s;
      ST_BYZERO: stall_s = ~div_bus.annul_i;
      ST_ON:     stall_s = ~div_bus.annul_i;
      ST_END:    stall_s = 1'b0;
      default:   stall_s = 1'b0;
    endcase
  end

  // Datapath next values: capture operands as magnitudes, iterate, apply the sign fix on the last step.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    result_d  = result_q;
    ready_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (div_bus.opdata2_i != 32'd0)) begin
          signed_d  = div_bus.signed_div_i;
          sign1_d   = div_bus.opdata1_i[31];
          sign2_d   = div_bus.opdata2_i[31];
          acc_d     = {33'd0, cond_neg(div_bus.opdata1_i, div_bus.signed_div_i & div_bus.opdata1_i[31])};
          divisor_d = cond_neg(div_bus.opdata2_i, div_bus.signed_div_i & div_bus.opdata2_i[31]);
          cnt_d     = 6'd0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_BYZERO: begin
        if (!div_bus.annul_i) begin
          result_d = 64'd0;
          ready_d  = 1'b1;
        end else begin
          ready_d = 1'b0;
        end
      end
      ST_ON: begin
        if (!div_bus.annul_i) begin
          acc_d = step_s;
          cnt_d = cnt_q + 6'd1;
          if (last_step_s) begin
            result_d = {cond_neg(step_s[63:32], signed_q & sign1_q),
                        cond_neg(step_s[31:0], signed_q & (sign1_q ^ sign2_q))};
            ready_d  = 1'b1;
          end else begin
            ready_d = 1'b0;
          end
        end else begin
          ready_d = 1'b0;
        end
      end
      ST_END:  ready_d = 1'b0;
      default: ready_d = 1'b0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 6'd0;
      acc_q     <= 65'd0;
      divisor_q <= 32'd0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign div_bus.result_o = result_q;
  assign div_bus.ready_o  = ready_q;
  assign div_bus.stall_o  = stall_s;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, monitor checks them on ready_o.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          at;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic with truncating signed division.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Monitor: every ready_o must match the oldest pending expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.ready_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready: ready_o=1 with result %h, expected no ready (cycle %0d)", bus.result_o, cyc);
        end else begin
          e = sb.pop_front();
          check("result", bus.result_o, e.res);
          check("ready_cycle", 64'(cyc), 64'(e.at));
        end
      end
    end
  end

  // mode 0: normal; 1: annul at cycle 'at'; 2: reset pulse at cycle 'at'. Called at a negedge.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int mode, input int at);
    int c0;
    int k;
    int lat;
    logic [63:0] e;
    e   = ref_div(a, b, s);
    lat = (b == 32'd0) ? 2 : 33;
    bus.start_i      = 1'b1;
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    c0 = cyc;
    k  = 0;
    if (mode == 0) sb.push_back('{e, c0 + lat});
    #1 check("stall_on_start", 64'(bus.stall_o), 64'd1);
    forever begin
      @(negedge clk);
      k = cyc - c0;
      if (mode != 0 && k == at) begin
        if (mode == 1) begin
          bus.annul_i = 1'b1;
          #1 check("stall_annul", 64'(bus.stall_o), 64'd0);
        end else begin
          rst = 1'b1;
          bus.start_i = 1'b0;
          #1;
          check("rst_result", bus.result_o, 64'd0);
          check("rst_ready", 64'(bus.ready_o), 64'd0);
          check("rst_stall", 64'(bus.stall_o), 64'd0);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        rst = 1'b0;
        #1 check("idle_after_abort", 64'(bus.stall_o), 64'd0);
        repeat (36) @(negedge clk);
        return;
      end
      #1;
      if (bus.stall_o == 1'b0) break;
      if (k > 40) begin
        checks++;
        failures++;
        $display("FAIL stall_timeout: stall_o still 1 after %0d cycles, expected release at %0d", k, lat);
        break;
      end
    end
    check("latency", 64'(k), 64'(lat));
    @(negedge clk);
    bus.start_i = 1'b0;
    check("result_hold", bus.result_o, e);
  endtask

  initial begin : driver
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    int          sel;
    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.annul_i      = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_result", bus.result_o, 64'd0);
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_stall", 64'(bus.stall_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_stall", 64'(bus.stall_o), 64'd0);

    run_div(32'd100, 32'd7, 1'b0, 0, 0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0);
    run_div(32'd123, 32'd0, 1'b0, 0, 0);
    run_div(32'h8000_0000, 32'd0, 1'b1, 0, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0);

    run_div(32'd1000, 32'd3, 1'b0, 1, 10);
    run_div(32'd1000, 32'd3, 1'b0, 0, 0);

    run_div(32'd55, 32'd5, 1'b0, 2, 15);
    run_div(32'hDEAD_BEEF, 32'd1234, 1'b0, 0, 0);
    run_div(32'hCAFE_F00D, 32'hFFFF_FF00, 1'b1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      b   = $urandom;
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       a = 32'h8000_0000;
        default: b = b >> $urandom_range(0, 31);
      endcase
      if (b == 32'd0 && sel != 0) b = 32'd1;
      run_div(a, b, s, 0, 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start_i  input  1  EX-stage divide request; held high by the pipeline while stall_o is high.
REQ-006 signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned divide (DIVU); sampled with start_i.
REQ-007 annul_i  input  1  abort request from the exception flush path.
REQ-008 opdata1_i  input  32  dividend.
REQ-009 opdata2_i  input  32  divisor.
REQ-010 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-011 ready_o  output  1  result_o is valid this cycle.
REQ-012 stall_o  output  1  feeds the hazard unit's stall_divE input.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, BYZERO, ON, END.
REQ-014 IDLE with start_i=1, annul_i=0 and opdata2_i=0 SHALL go to BYZERO.
REQ-015 IDLE with start_i=1, annul_i=0 and opdata2_i!=0 SHALL go to ON. It SHALL capture the operands, the sign flags and signed_div_i, and clear the 6-bit iteration counter.
REQ-016 IDLE with start_i=0 or annul_i=1 SHALL stay in IDLE. Operand changes outside the IDLE start cycle SHALL be ignored.
REQ-017 Signed mode SHALL convert negative operands to magnitude (two's complement) before iterating. Unsigned mode SHALL use the raw operands.
REQ-018 ON SHALL perform one restoring shift-subtract step per cycle on a 65-bit partial-remainder/quotient register. After 32 steps (counter == 32) it SHALL go to END.
REQ-019 Final sign fix: quotient negated iff signed mode and dividend sign != divisor sign; remainder negated iff signed mode and dividend negative.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-021 BYZERO SHALL go to END next cycle with result 64'h0.
REQ-022 END SHALL assert ready_o=1 with the final result for exactly one cycle, then go unconditionally to IDLE.
REQ-023 result_o SHALL hold its last value until the next accepted start. ready_o SHALL be 0 in all states other than END.
REQ-024 stall_o SHALL be combinational: 1 when (IDLE and start_i and !annul_i), or in BYZERO, or in ON. It SHALL be 0 in END and otherwise.
REQ-025 Latency: start accepted in cycle 0, ON spans cycles 1..32, ready_o=1 in cycle 33. Divide-by-zero gives ready_o=1 in cycle 2.
REQ-026 annul_i=1 in BYZERO or ON SHALL force IDLE at the next edge. stall_o SHALL drop in that same cycle, and ready_o SHALL not assert for the aborted operation.
REQ-027 annul_i in END SHALL be ignored; the result is already committed to the pipeline.
REQ-028 start_i high in IDLE immediately after END SHALL begin a new division (back-to-back divides).

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE, counter 0, result_o 0, ready_o 0, internal registers 0.
REQ-030 Reset mid-operation SHALL discard the division; no ready_o SHALL follow after rst is released.

Verification
REQ-031 Unsigned 100 / 7, start at cycle 0 -> stall_o=1 in cycles 0..32; cycle 33 ready_o=1, result_o = {32'd2, 32'd14}.
REQ-032 Signed -7 / 2 -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}; signed 7 / -2 -> {32'h1, 32'hFFFFFFFD}.
REQ-033 Divisor 0, either mode -> ready_o=1 in cycle 2, result_o = 64'h0, stall_o low in cycle 2.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF -> result_o = {32'h0, 32'h80000000}.
REQ-035 annul_i=1 at cycle 10 of an ON divide -> stall_o=0 in cycle 10, state IDLE at cycle 11, ready_o never asserts. A following start produces a correct result.
REQ-036 rst pulse at cycle 15 of a divide -> outputs 0 immediately. Two back-to-back divides after release produce correct, independent results with ready_o in cycles 33 and 67.
